// File: rtl/fifo_sync_fwft.sv
// Synchronous FIFO with registered-read or first-word-fall-through output.
// Ports: clk, rst (async high); wr_en/data_in push; rd_en pops to data_out;
//   clr_err clears the sticky overflow/underflow flags; full, empty,
//   almost_full, almost_empty and count report occupancy.
module fifo_sync_fwft #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // A write into a full FIFO is fine when a read frees a slot the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Later assignment wins: a fresh error in the clear cycle keeps the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (wr_en && !wr_acc)
        overflow <= 1'b1;
      if (rd_en && !rd_acc)
        underflow <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= data_in;
  end

  generate
    if (FWFT == 0) begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          dout_q <= '0;
        else if (rd_acc)
          dout_q <= mem[rd_ptr];
      end

      assign data_out = dout_q;
    end else begin : g_fwft
      // Head word is always on the output; valid while not empty.
      assign data_out = mem[rd_ptr];
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Directed bench for fifo_sync_fwft: one registered-read and one FWFT
// instance share the same stimulus; expected values are hand-computed.
module tb_fifo_sync_fwft;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] data_in;

  logic [7:0] d0_data;
  logic       d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_udf;
  logic [5:0] d0_count;

  logic [7:0] d1_data;
  logic       d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_udf;
  logic [5:0] d1_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_sync_fwft #(.FWFT(0)) u_reg (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .data_in      (data_in),
    .clr_err      (clr_err),
    .data_out     (d0_data),
    .full         (d0_full),
    .empty        (d0_empty),
    .almost_full  (d0_af),
    .almost_empty (d0_ae),
    .count        (d0_count),
    .overflow     (d0_ovf),
    .underflow    (d0_udf)
  );

  fifo_sync_fwft #(.FWFT(1)) u_fwft (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .data_in      (data_in),
    .clr_err      (clr_err),
    .data_out     (d1_data),
    .full         (d1_full),
    .empty        (d1_empty),
    .almost_full  (d1_af),
    .almost_empty (d1_ae),
    .count        (d1_count),
    .overflow     (d1_ovf),
    .underflow    (d1_udf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r,
                     input logic [7:0] d, input logic c);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 8'h00;
    clr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    repeat (2) @(posedge clk);
    #1;
    chk("rst count", d0_count, 0);
    chk("rst empty", d0_empty, 1);
    chk("rst full", d0_full, 0);
    chk("rst ae", d0_ae, 1);
    chk("rst af", d0_af, 0);
    chk("rst ovf", d0_ovf, 0);
    chk("rst udf", d0_udf, 0);
    chk("rst data", d0_data, 0);
    chk("rst f count", d1_count, 0);
    chk("rst f empty", d1_empty, 1);
    chk("rst f full", d1_full, 0);
    chk("rst f ae", d1_ae, 1);
    chk("rst f af", d1_af, 0);
    chk("rst f flags", {d1_ovf, d1_udf}, 0);
    rst = 1'b0;

    // fill 0x01..0x20 with level flag boundaries
    for (int i = 1; i <= 32; i++) begin
      cyc(1'b1, 1'b0, 8'(i), 1'b0);
      chk("fill count", d0_count, i);
      if (i == 1) begin
        chk("fwft first empty", d1_empty, 0);
        chk("fwft first data", d1_data, 8'h01);
      end
      if (i == 2)  chk("ae at 2", d0_ae, 1);
      if (i == 3)  chk("ae at 3", d0_ae, 0);
      if (i == 29) chk("af at 29", d0_af, 0);
      if (i == 30) chk("af at 30", d0_af, 1);
      if (i == 31) chk("full at 31", d0_full, 0);
      if (i == 32) chk("full at 32", d0_full, 1);
    end
    chk("fwft full", d1_full, 1);

    // drain in order
    for (int i = 1; i <= 32; i++) begin
      chk("fwft head", d1_data, i);
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain data", d0_data, i);
    end
    quiet();
    chk("drain empty", d0_empty, 1);
    chk("drain f empty", d1_empty, 1);
    chk("drain ovf", d0_ovf, 0);
    chk("drain udf", d0_udf, 0);

    // full + simultaneous read/write
    for (int i = 1; i <= 32; i++)
      cyc(1'b1, 1'b0, 8'(i), 1'b0);
    chk("refill full", d0_full, 1);
    cyc(1'b1, 1'b1, 8'hAA, 1'b0);
    chk("rw full count", d0_count, 32);
    chk("rw full ovf", d0_ovf, 0);
    chk("rw full data", d0_data, 8'h01);
    chk("rw full f head", d1_data, 8'h02);
    for (int i = 2; i <= 33; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      chk("rw drain", d0_data, (i <= 32) ? i : 32'hAA);
    end
    quiet();
    chk("rw drain empty", d0_empty, 1);

    // underflow and clear
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("udf set", d0_udf, 1);
    chk("udf data hold", d0_data, 8'hAA);
    chk("udf count", d0_count, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("udf clr", d0_udf, 0);
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    chk("udf clr+err", d0_udf, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("udf clr2", d0_udf, 0);

    // empty + simultaneous read/write
    cyc(1'b1, 1'b1, 8'h33, 1'b0);
    chk("ew count", d0_count, 1);
    chk("ew udf", d0_udf, 1);
    chk("ew data hold", d0_data, 8'hAA);
    chk("ew f data", d1_data, 8'h33);
    chk("ew f empty", d1_empty, 0);

    // overflow on rejected write
    for (int i = 2; i <= 32; i++)
      cyc(1'b1, 1'b0, 8'(i), 1'b0);
    chk("ovf pre full", d0_full, 1);
    cyc(1'b1, 1'b0, 8'hEE, 1'b0);
    chk("ovf set", d0_ovf, 1);
    chk("ovf count", d0_count, 32);
    chk("ovf f head", d1_data, 8'h33);
    chk("ovf data hold", d0_data, 8'hAA);
    for (int i = 0; i < 15; i++)
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
    quiet();
    chk("pre rst count", d0_count, 17);
    chk("pre rst ovf", d0_ovf, 1);
    chk("pre rst data", d0_data, 8'h0F);

    // async reset between edges
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst count", d0_count, 0);
    chk("arst empty", d0_empty, 1);
    chk("arst full", d0_full, 0);
    chk("arst ae", d0_ae, 1);
    chk("arst af", d0_af, 0);
    chk("arst ovf", d0_ovf, 0);
    chk("arst udf", d0_udf, 0);
    chk("arst data", d0_data, 0);
    chk("arst f count", d1_count, 0);
    #1 rst = 1'b0;

    // first write after reset lands in slot 0; FWFT fall-through
    cyc(1'b1, 1'b0, 8'h5C, 1'b0);
    chk("fwft 5c empty", d1_empty, 0);
    chk("fwft 5c data", d1_data, 8'h5C);
    chk("post rst count", d0_count, 1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("post rst read", d0_data, 8'h5C);
    chk("fwft pop empty", d1_empty, 1);

    // pointer wrap with paired write/read
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
    for (int k = 0; k < 40; k++) begin
      chk("wrap f head", d1_data, 8'h80 + k);
      cyc(1'b1, 1'b1, 8'(8'h83 + k), 1'b0);
      chk("wrap data", d0_data, 8'h80 + k);
    end
    chk("wrap count", d0_count, 3);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      chk("wrap tail", d0_data, 8'hA8 + i);
    end
    quiet();
    chk("end empty", d0_empty, 1);
    chk("end flags", {d0_ovf, d0_udf, d1_ovf, d1_udf}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
